multi_mode_ff_bank: RTL and testbench
=====================================

MULTI_MODE_FF_BANK -- requirements
Module: multi_mode_ff_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of storage bits (1..32).
REQ-002 Parameter CNT_W, default 8: width of the invalid-event counter (2..16).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: Clk and Rst.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Rst  input  1  synchronous active-high reset.
REQ-006 En  input  1  update enable; state changes only when 1.
REQ-007 Mode  input  2  00 = SR, 01 = JK, 10 = D, 11 = T; one mode applies to all bits.
REQ-008 S  input  WIDTH  per-bit S, J, D or T input, depending on Mode.
REQ-009 R  input  WIDTH  per-bit R or K input; ignored in D and T modes.
REQ-010 Clr_err  input  1  clears Err_sticky and Err_cnt.
REQ-011 Q  output  WIDTH  stored value.
REQ-012 Q_bar  output  WIDTH  bitwise complement of Q at all times.
REQ-013 Invalid  output  1  high for one cycle after an SR-mode edge where any bit had S=R=1.
REQ-014 Err_sticky  output  1  set by any invalid event; held until cleared.
REQ-015 Err_cnt  output  CNT_W  saturating count of cycles with an invalid event.

Function
REQ-016 All state SHALL update only on the rising edge of Clk; there are no combinational paths from inputs to Q.
REQ-017 When En=0, Q SHALL hold its value and no invalid event SHALL be generated, whatever Mode, S and R are.
REQ-018 When En=1, each bit i SHALL take the next value for the current mode, as follows.
REQ-019 SR mode: S=0,R=0 holds; S=1,R=0 sets to 1; S=0,R=1 clears to 0; S=1,R=1 holds and flags an invalid event.
REQ-020 JK mode: J=0,K=0 holds; J=1,K=0 sets to 1; J=0,K=1 clears to 0; J=1,K=1 toggles; no invalid event.
REQ-021 D mode: Q[i] SHALL be loaded with S[i].
REQ-022 T mode: Q[i] SHALL toggle when S[i]=1 and hold when S[i]=0.
REQ-023 Bits SHALL be evaluated independently; an invalid bit SHALL NOT affect the update of any other bit.
REQ-024 An invalid event is a cycle with En=1, Mode=00 and (S & R) not equal to 0.
REQ-025 Invalid SHALL be registered: high in the cycle after the event edge, and low otherwise.
REQ-026 On an invalid event, Err_cnt SHALL increment by 1 per cycle, not per bit.
REQ-027 Err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 On an invalid event, Err_sticky SHALL be set to 1.
REQ-029 Clr_err=1 with no event SHALL give Err_cnt=0 and Err_sticky=0 at the next edge.
REQ-030 Clr_err=1 in the same cycle as an event SHALL give Err_cnt=1 and Err_sticky=1, so the event is not lost.
REQ-031 Clr_err SHALL NOT affect Q or Invalid.
REQ-032 A change of Mode SHALL take effect on the same edge, with no pipeline.

Reset
REQ-033 While Rst is sampled high, at each edge: Q=0, Q_bar=all ones, Invalid=0, Err_sticky=0, Err_cnt=0.
REQ-034 Rst SHALL override En, Mode and Clr_err.
REQ-035 Rst asserted mid-operation SHALL discard any event pending in that cycle.
REQ-036 Outputs SHALL be undefined only before the first reset edge; no X SHALL propagate after reset.

Verification
REQ-037 WIDTH=4, after reset: Mode=00, En=1, S=0101, R=1010 -> Q=0101, Q_bar=1010; then S=1010, R=0101 -> Q=1010.
REQ-038 SR invalid: Q=1010, S=1100, R=0110 -> Q=1000 (bit2 holds, bit3 sets, bit1 clears), Invalid=1 for one cycle, Err_cnt=1, Err_sticky=1.
REQ-039 JK and T: Q=0000, Mode=01, J=K=1111 for 3 edges -> Q=1111, 0000, 1111; then Mode=11, T=0011 -> Q=1100; Invalid stays 0 throughout.
REQ-040 Saturation: CNT_W=2, 5 consecutive invalid cycles -> Err_cnt=1, 2, 3, 3, 3; then Clr_err with an event -> Err_cnt=1; Clr_err alone -> Err_cnt=0, Err_sticky=0.
REQ-041 En=0 with Mode=00, S=R=1111 -> Q unchanged, Invalid=0, Err_cnt unchanged.
REQ-042 Rst in the same cycle as an invalid event with Q=1111 -> Q=0000, Invalid=0, Err_cnt=0 next cycle.

Source files
------------

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH flip-flops that act together as SR, JK, D or T storage,
// with invalid-SR detection, a sticky error flag and a saturating error counter.
module multi_mode_ff_bank #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             Clr_err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic             Invalid,
    output logic             Err_sticky,
    output logic [CNT_W-1:0] Err_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             invalid_q, invalid_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             event_w;

    assign event_w = En && (Mode == MODE_SR) && ((S & R) != '0);

    // S=R=1 falls into the hold term, so an invalid bit never disturbs its neighbours.
    always_comb begin
        q_d = q_q;
        if (En) begin
            case (Mode)
                MODE_SR: q_d = (S & ~R) | (q_q & (S | ~R));
                MODE_JK: q_d = (S & ~q_q) | (~R & q_q);
                MODE_D:  q_d = S;
                MODE_T:  q_d = q_q ^ S;
                default: q_d = q_q;
            endcase
        end
    end

    // A clear that coincides with an event keeps that event counted.
    always_comb begin
        invalid_d = event_w;
        sticky_d  = sticky_q | event_w;
        cnt_d     = cnt_q;
        if (Clr_err) begin
            sticky_d = event_w;
            cnt_d    = event_w ? CNT_ONE : '0;
        end else if (event_w && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            q_q       <= '0;
            invalid_q <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            q_q       <= q_d;
            invalid_q <= invalid_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Q          = q_q;
    assign Q_bar      = ~q_q;
    assign Invalid    = invalid_q;
    assign Err_sticky = sticky_q;
    assign Err_cnt    = cnt_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench for multi_mode_ff_bank: a behavioural model checked every cycle
// plus literal expectations taken from hand-worked sequences.
module tb_multi_mode_ff_bank;
  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] s = '0;
  logic [WIDTH-1:0] r = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] q, q_bar;
  logic             invalid, err_sticky;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  multi_mode_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Rst(rst), .En(en), .Mode(mode), .S(s), .R(r), .Clr_err(clr_err),
    .Q(q), .Q_bar(q_bar), .Invalid(invalid), .Err_sticky(err_sticky), .Err_cnt(err_cnt)
  );

  // clock
  always #5 clk = ~clk;

  // behavioural model: rule tables per bit, integer counter clamped at saturation
  bit m_valid = 0;
  bit m_q[WIDTH];
  bit m_inv, m_sticky;
  int m_cnt;

  always @(posedge clk) begin
    bit ev;
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) m_q[i] = 0;
      m_inv = 0; m_sticky = 0; m_cnt = 0; m_valid = 1;
    end else begin
      ev = 0;
      if (en && mode == 2'd0)
        for (int i = 0; i < WIDTH; i++) if (s[i] && r[i]) ev = 1;
      if (en) begin
        for (int i = 0; i < WIDTH; i++) begin
          case (mode)
            2'd0: if (s[i] && !r[i]) m_q[i] = 1; else if (!s[i] && r[i]) m_q[i] = 0;
            2'd1: if (s[i] && r[i]) m_q[i] = !m_q[i];
                  else if (s[i]) m_q[i] = 1; else if (r[i]) m_q[i] = 0;
            2'd2: m_q[i] = s[i];
            default: if (s[i]) m_q[i] = !m_q[i];
          endcase
        end
      end
      m_inv = ev;
      if (clr_err) begin
        m_cnt = ev ? 1 : 0;
        m_sticky = ev;
      end else if (ev) begin
        m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
        m_sticky = 1;
      end
    end
  end

  function automatic int model_q_int();
    int v = 0;
    for (int i = 0; i < WIDTH; i++) if (m_q[i]) v += (1 << i);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare DUT against model on every cycle after the first reset edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q", int'(q), model_q_int());
      check("model_q_bar", int'(q_bar), (~model_q_int()) & ((1 << WIDTH) - 1));
      check("model_invalid", int'(invalid), int'(m_inv));
      check("model_sticky", int'(err_sticky), int'(m_sticky));
      check("model_cnt", int'(err_cnt), m_cnt);
    end
  end

  // driver: apply one cycle of inputs, return just after the following negedge
  task automatic step(input logic rst_v, input logic en_v, input logic [1:0] mode_v,
                      input logic [3:0] s_v, input logic [3:0] r_v, input logic clr_v);
    rst = rst_v; en = en_v; mode = mode_v; s = s_v; r = r_v; clr_err = clr_v;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    step(1, 1, 2'b10, 4'hF, 4'h0, 0);
    step(1, 0, 2'b00, 4'h0, 4'h0, 0);
    check("rst_q", int'(q), 0);
    check("rst_q_bar", int'(q_bar), 4'hF);
    check("rst_invalid", int'(invalid), 0);
    check("rst_cnt", int'(err_cnt), 0);
    check("rst_sticky", int'(err_sticky), 0);

    // SR set/clear
    step(0, 1, 2'b00, 4'b0101, 4'b1010, 0);
    check("sr1_q", int'(q), 4'b0101);
    check("sr1_q_bar", int'(q_bar), 4'b1010);
    step(0, 1, 2'b00, 4'b1010, 4'b0101, 0);
    check("sr2_q", int'(q), 4'b1010);

    // SR invalid on bit2 only
    step(0, 1, 2'b00, 4'b1100, 4'b0110, 0);
    check("inv_q", int'(q), 4'b1000);
    check("inv_flag", int'(invalid), 1);
    check("inv_cnt", int'(err_cnt), 1);
    check("inv_sticky", int'(err_sticky), 1);
    step(0, 1, 2'b00, 4'b0000, 4'b0000, 0);
    check("inv_drop", int'(invalid), 0);
    check("inv_cnt_hold", int'(err_cnt), 1);

    // JK toggle then T
    step(0, 1, 2'b10, 4'b0000, 4'b1111, 0);
    check("d_zero", int'(q), 0);
    step(0, 1, 2'b01, 4'hF, 4'hF, 0);
    check("jk1", int'(q), 4'hF);
    step(0, 1, 2'b01, 4'hF, 4'hF, 0);
    check("jk2", int'(q), 4'h0);
    step(0, 1, 2'b01, 4'hF, 4'hF, 0);
    check("jk3", int'(q), 4'hF);
    check("jk_invalid", int'(invalid), 0);
    step(0, 1, 2'b11, 4'b0011, 4'hF, 0);
    check("t_q", int'(q), 4'b1100);
    check("t_invalid", int'(invalid), 0);

    // En=0 blocks updates and events
    step(0, 0, 2'b00, 4'hF, 4'hF, 0);
    check("en0_q", int'(q), 4'b1100);
    check("en0_invalid", int'(invalid), 0);
    check("en0_cnt", int'(err_cnt), 1);

    // clear, then saturation
    step(0, 1, 2'b10, 4'b1100, 4'h0, 1);
    check("clr_cnt", int'(err_cnt), 0);
    check("clr_sticky", int'(err_sticky), 0);
    check("clr_q", int'(q), 4'b1100);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 2'b00, 4'hF, 4'hF, 0);
      check($sformatf("sat_cnt%0d", k), int'(err_cnt), (k < 3) ? k + 1 : 3);
    end
    check("sat_q", int'(q), 4'b1100);
    step(0, 1, 2'b00, 4'hF, 4'hF, 1);
    check("clr_ev_cnt", int'(err_cnt), 1);
    check("clr_ev_sticky", int'(err_sticky), 1);
    check("clr_ev_invalid", int'(invalid), 1);
    step(0, 1, 2'b00, 4'h0, 4'h0, 1);
    check("clr2_cnt", int'(err_cnt), 0);
    check("clr2_sticky", int'(err_sticky), 0);

    // reset discards a coincident event
    step(0, 1, 2'b10, 4'hF, 4'h0, 0);
    step(0, 1, 2'b00, 4'hF, 4'hF, 0);
    check("pre_rst_cnt", int'(err_cnt), 1);
    step(1, 1, 2'b00, 4'hF, 4'hF, 0);
    check("rst_ev_q", int'(q), 0);
    check("rst_ev_invalid", int'(invalid), 0);
    check("rst_ev_cnt", int'(err_cnt), 0);

    // pseudo-random directed sweep checked by the model
    for (int k = 0; k < 40; k++)
      step(0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 7) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
